// File: rtl/vrased_rst_pkg.sv
// Shared types and constants for the VRASED reset controller.
// Optional feature macro (used by vrased_reset_ctrl): VRASED_RST_COUNT_EN.
package vrased_rst_pkg;

    localparam int VIOL_W  = 6;
    localparam int CAUSE_W = 7;
    localparam int CNT_W   = 8;

    localparam int CAUSE_XSTACK     = 0;
    localparam int CAUSE_AC         = 1;
    localparam int CAUSE_ATOMIC     = 2;
    localparam int CAUSE_DMA_AC     = 3;
    localparam int CAUSE_DMA_DETECT = 4;
    localparam int CAUSE_DMA_XSTACK = 5;
    localparam int CAUSE_TIMEOUT    = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        WAIT_PC = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vrased_rst_timer.sv
// Loadable 8-bit down-counter that stops at zero instead of wrapping.
module vrased_rst_timer
    import vrased_rst_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // next count: load has priority, decrement holds at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == 8'd0);

endmodule

// File: rtl/vrased_reset_ctrl.sv
// VRASED reset controller: turns monitor violations into a held PUC and waits for the CPU to restart.
// Define VRASED_RST_COUNT_EN to build the saturating episode counter on viol_count.
module vrased_reset_ctrl
    import vrased_rst_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          HOLD_CYCLES   = 4,
    parameter int          WAIT_TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [VIOL_W-1:0]  viol,
    input  logic [15:0]        pc,
    input  logic               cause_clr,
    output logic               puc_req,
    output logic [CAUSE_W-1:0] cause,
    output logic               busy,
    output logic [CNT_W-1:0]   viol_count
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_TIMEOUT - 1);

    state_e             state_d, state_q;
    logic               puc_q, busy_q;
    logic [CAUSE_W-1:0] cause_d, cause_q;
    logic               hold_load_s, hold_dec_s, hold_zero_s;
    logic               tmo_load_s, tmo_dec_s, tmo_zero_s;
    logic [CNT_W-1:0]   hold_val_s, tmo_val_s;
    logic               enter_s, timeout_s, viol_any_s, pc_match_s;
    logic               unused_val_s;

    assign viol_any_s   = (viol != 6'd0);
    assign pc_match_s   = (pc == RESET_HANDLER);
    assign unused_val_s = ^{hold_val_s, tmo_val_s};

    vrased_rst_timer u_hold (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (hold_load_s),
        .dec      (hold_dec_s),
        .load_val (HOLD_LOAD),
        .value    (hold_val_s),
        .zero     (hold_zero_s)
    );

    vrased_rst_timer u_tmo (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmo_load_s),
        .dec      (tmo_dec_s),
        .load_val (WAIT_LOAD),
        .value    (tmo_val_s),
        .zero     (tmo_zero_s)
    );

    // next-state, counter control and cause update
    always_comb begin
        state_d     = state_q;
        hold_load_s = 1'b0;
        hold_dec_s  = 1'b0;
        tmo_load_s  = 1'b0;
        tmo_dec_s   = 1'b0;
        enter_s     = 1'b0;
        timeout_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (viol_any_s) begin
                    state_d     = ASSERT;
                    hold_load_s = 1'b1;
                    enter_s     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ASSERT: begin
                if (viol_any_s) begin
                    hold_load_s = 1'b1;
                end else if (hold_zero_s) begin
                    state_d    = WAIT_PC;
                    tmo_load_s = 1'b1;
                end else begin
                    hold_dec_s = 1'b1;
                end
            end
            WAIT_PC: begin
                timeout_s = tmo_zero_s && !pc_match_s;
                // a new violation outranks a pc match in the same cycle
                if (viol_any_s || timeout_s) begin
                    state_d     = ASSERT;
                    hold_load_s = 1'b1;
                    enter_s     = 1'b1;
                end else if (pc_match_s) begin
                    state_d = IDLE;
                end else begin
                    tmo_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cause_d = (cause_clr ? 7'd0 : cause_q) | {timeout_s, viol};
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            puc_q   <= 1'b0;
            busy_q  <= 1'b0;
            cause_q <= 7'd0;
        end else begin
            state_q <= state_d;
            puc_q   <= (state_d == ASSERT);
            busy_q  <= (state_d != IDLE);
            cause_q <= cause_d;
        end
    end

    assign puc_req = puc_q;
    assign busy    = busy_q;
    assign cause   = cause_q;

`ifdef VRASED_RST_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // episode counter, bumped only when an episode starts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 8'd0;
        end else if (enter_s) begin
            count_q <= sat_inc(count_q);
        end else begin
            count_q <= count_q;
        end
    end

    assign viol_count = count_q;
`else
    logic unused_enter_s;
    assign unused_enter_s = enter_s;
    assign viol_count     = 8'd0;
`endif

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Scoreboard bench for vrased_reset_ctrl: directed episodes, then random violations/pc/clear traffic.
module tb_vrased_reset_ctrl;
    import vrased_rst_pkg::*;

    localparam logic [15:0] RH   = 16'hFFFE;
    localparam int          HOLD = 4;
    localparam int          WAIT = 16;
`ifdef VRASED_RST_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    typedef struct {
        logic       puc;
        logic       busy;
        logic [6:0] cause;
        logic [7:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  viol = 6'd0;
    logic [15:0] pc = 16'd0;
    logic        cause_clr = 1'b0;
    logic        puc_req, busy;
    logic [6:0]  cause;
    logic [7:0]  viol_count;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    // reference model: remaining asserted / waiting cycles
    int         m_hold, m_wait, m_cnt;
    logic [6:0] m_cause;

    vrased_reset_ctrl #(.RESET_HANDLER(RH), .HOLD_CYCLES(HOLD), .WAIT_TIMEOUT(WAIT)) dut (
        .clk(clk), .reset_n(reset_n), .viol(viol), .pc(pc), .cause_clr(cause_clr),
        .puc_req(puc_req), .cause(cause), .busy(busy), .viol_count(viol_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_wait = 0; m_cnt = 0; m_cause = 7'd0;
    endtask

    task automatic model_step(input logic [5:0] v, input logic [15:0] p, input logic clr);
        bit to, trig;
        exp_t e;
        to   = (m_hold == 0) && (m_wait == 1) && (p != RH);
        trig = 1'b0;
        if (m_hold > 0) begin
            if (v != 6'd0) m_hold = HOLD;
            else if (m_hold == 1) begin m_hold = 0; m_wait = WAIT; end
            else m_hold--;
        end else if (m_wait > 0) begin
            if (v != 6'd0 || to) begin m_hold = HOLD; m_wait = 0; trig = 1'b1; end
            else if (p == RH) m_wait = 0;
            else m_wait--;
        end else if (v != 6'd0) begin
            m_hold = HOLD; trig = 1'b1;
        end
        m_cause = (clr ? 7'd0 : m_cause) | {to, v};
        if (trig && COUNT_EN && m_cnt < 255) m_cnt++;
        e.puc = (m_hold > 0); e.busy = (m_hold > 0) || (m_wait > 0);
        e.cause = m_cause; e.cnt = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    // drive one cycle of inputs; returns shortly after the sampling edge
    task automatic step(input logic [5:0] v, input logic [15:0] p, input logic clr);
        @(negedge clk);
        viol = v; pc = p; cause_clr = clr;
        model_step(v, p, clr);
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_puc"}, 32'(puc_req), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cause"}, 32'(cause), 32'd0);
        check({tag, "_cnt"}, 32'(viol_count), 32'd0);
        exp_q.delete();
        model_reset();
        viol = 6'd0; pc = 16'd0; cause_clr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // monitor: every cycle the DUT presents outputs; compare against the queued expectation
    always @(posedge clk) begin
        #1;
        if (reset_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_puc", 32'(puc_req), 32'(e.puc));
            check("sb_busy", 32'(busy), 32'(e.busy));
            check("sb_cause", 32'(cause), 32'(e.cause));
            check("sb_count", 32'(viol_count), 32'(e.cnt));
        end
    end

    initial begin
        int n;
        model_reset();
        #23;
        check("rst_puc", 32'(puc_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_cnt", 32'(viol_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // single pulse, then an extension sampled on the third ASSERT edge
        n = 0;
        step(6'b000010, 16'd0, 1'b0);
        if (puc_req) n++;
        check("pulse_cause", 32'(cause), 32'h02);
        check("pulse_busy", 32'(busy), 32'd1);
        step(6'd0, 16'd0, 1'b0);      if (puc_req) n++;
        step(6'b000001, 16'd0, 1'b0); if (puc_req) n++;
        for (int i = 0; i < 4; i++) begin
            step(6'd0, 16'd0, 1'b0);
            if (puc_req) n++;
        end
        check("ext_puc_cycles", 32'(n), 32'd6);
        check("ext_cause", 32'(cause), 32'h03);
        check("ext_cnt", 32'(viol_count), COUNT_EN ? 32'd1 : 32'd0);
        check("wait_busy", 32'(busy), 32'd1);

        // no pc match: re-assert after exactly WAIT cycles
        for (int i = 0; i < WAIT; i++) begin
            step(6'd0, 16'd0, 1'b0);
            if (i < WAIT - 1) check("wait_puc_low", 32'(puc_req), 32'd0);
        end
        check("tmo_puc", 32'(puc_req), 32'd1);
        check("tmo_cause6", 32'(cause[CAUSE_TIMEOUT]), 32'd1);
        check("tmo_cnt", 32'(viol_count), COUNT_EN ? 32'd2 : 32'd0);

        // release, then pc match on the second WAIT_PC cycle
        for (int i = 0; i < HOLD; i++) step(6'd0, 16'd0, 1'b0);
        check("rel_puc", 32'(puc_req), 32'd0);
        step(6'd0, 16'd0, 1'b0);
        step(6'd0, RH, 1'b0);
        check("match_busy", 32'(busy), 32'd0);

        // clear and set together: set wins
        step(6'b010000, 16'd0, 1'b1);
        check("clr_set_cause", 32'(cause), 32'h10);

        // asynchronous reset mid-episode
        step(6'd0, 16'd0, 1'b0);
        async_reset("midrst");

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [5:0]  v;
            logic [15:0] p;
            v = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            p = ($urandom_range(0, 19) == 0) ? RH : 16'($urandom);
            step(v, p, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 399) == 0) begin
                #2;
                async_reset("rndrst");
            end
        end

        step(6'd0, 16'd0, 1'b0);
        @(posedge clk);
        #3;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vrased_reset_ctrl.md
VRASED_RESET_CTRL -- requirements
Module: vrased_reset_ctrl

Interface
REQ-001 Parameter RESET_HANDLER, 16'h0000: address the CPU fetches first after reset.
REQ-002 Parameter HOLD_CYCLES, 4: cycles puc_req stays asserted per reset episode; legal range 1..255.
REQ-003 Parameter WAIT_TIMEOUT, 16: maximum cycles after release for pc to reach RESET_HANDLER; legal range 1..255.
REQ-004 clk  input  1: single clock; all state updates on posedge clk.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 viol  input  6: violation requests, one per monitor: bit0 X_stack, bit1 AC, bit2 atomicity, bit3 dma_AC, bit4 dma_detect, bit5 dma_X_stack.
REQ-007 pc  input  16: CPU program counter.
REQ-008 cause_clr  input  1: single-cycle pulse that clears cause.
REQ-009 puc_req  output  1: registered reset request to the CPU (PUC).
REQ-010 cause  output  7: sticky cause flags; bits 5:0 mirror viol, bit6 marks a restart timeout.
REQ-011 busy  output  1: high in any state other than IDLE.
REQ-012 viol_count  output  8: saturating count of reset episodes.

Function
REQ-013 FSM states: IDLE, ASSERT, WAIT_PC.
REQ-014 IDLE: if viol!=0 at a posedge, go to ASSERT; the hold counter loads HOLD_CYCLES-1.
REQ-015 ASSERT: puc_req=1 for exactly HOLD_CYCLES cycles, starting the cycle after the triggering edge.
REQ-016 ASSERT: viol!=0 reloads the hold counter to HOLD_CYCLES-1, which extends the episode.
REQ-017 ASSERT: counter==0 with viol==0 goes to WAIT_PC; the timeout counter loads WAIT_TIMEOUT-1.
REQ-018 WAIT_PC: puc_req=0.
REQ-019 WAIT_PC: pc==RESET_HANDLER with viol==0 goes to IDLE.
REQ-020 WAIT_PC: viol!=0 goes to ASSERT and has priority over a pc match in the same cycle.
REQ-021 WAIT_PC: timeout counter==0 without a pc match goes to ASSERT and sets cause[6].
REQ-022 cause[5:0] |= viol on every posedge.
REQ-023 Clearing: cause_clr clears all cause bits; a viol or timeout bit set in the same cycle survives (set wins).
REQ-024 cause_clr has no effect on FSM state or on puc_req.
REQ-025 busy is a registered decode of state != IDLE.
REQ-026 Counter widths: 8-bit hold and timeout counters; no wrap (reload only on state entry or per REQ-016).

Reset
REQ-027 reset_n low forces IDLE asynchronously, including mid-episode; the episode is abandoned.
REQ-028 Reset values: puc_req=0, busy=0, cause=0, viol_count=0, both counters=0.
REQ-029 After reset_n deasserts, viol is sampled on the first posedge.

Configuration
REQ-030 Macro VRASED_RST_COUNT_EN, when defined: viol_count increments by 1 on each IDLE->ASSERT and WAIT_PC->ASSERT transition, saturates at 255, and is never cleared by cause_clr.
REQ-031 Extensions in an ASSERT episode (REQ-016) do not increment viol_count.
REQ-032 Macro undefined: viol_count is tied to 0 and no counter flops exist.

Structure
REQ-033 Package vrased_rst_pkg holds:
- state enum (IDLE, ASSERT, WAIT_PC);
- cause bit index constants (CAUSE_XSTACK..CAUSE_DMA_XSTACK, CAUSE_TIMEOUT);
- widths VIOL_W=6, CAUSE_W=7, CNT_W=8.
REQ-034 One sub-module, vrased_rst_timer: loadable 8-bit down-counter with load, value and zero flag.
- Instantiated twice: hold counter and timeout counter.

Verification
REQ-035 HOLD_CYCLES=4, viol=6'b000010 pulsed 1 cycle from IDLE -> puc_req high exactly 4 cycles; cause=7'h02; busy high.
REQ-036 viol bit0 pulsed again in cycle 3 of ASSERT -> puc_req high 4 more cycles after that pulse (6 total); cause=7'h03; viol_count=1.
REQ-037 After release, pc=RESET_HANDLER on the 2nd WAIT_PC cycle -> IDLE next cycle; busy=0.
REQ-038 WAIT_TIMEOUT=16 with pc never matching -> re-ASSERT after 16 cycles; cause[6]=1; viol_count=2 (macro defined) or 0 (undefined).
REQ-039 cause_clr and viol bit4 in the same cycle -> cause=7'h10.
REQ-040 reset_n low during ASSERT -> puc_req, busy and cause are 0 immediately, without waiting for clk.
